// File: rtl/uart_word_packer_if.sv
// Byte-in / word-out bus of the UART word packer.
// master = byte source and memory sink, slave = packer.
interface uart_word_packer_if #(
  parameter int ADDR_W = 10
) ();
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_dv,
    output rx_byte,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  rx_dv,
    input  rx_byte,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/uart_word_packer.sv
// Packs UART bytes little-endian into 32-bit words and
// writes WORD_COUNT of them to sequential memory addresses.
module uart_word_packer #(
  parameter int WORD_COUNT   = 1024,
  parameter int ADDR_W       = 10,
  parameter int TIMEOUT_CLKS = 2000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  uart_word_packer_if.slave   bus,
  output logic                recv_done,
  output logic                frame_err,
  output logic                busy
);

  localparam int CNT_W =
    (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(WORD_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_idx;
  logic [23:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_maddr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_ferr;

  state_t            w_state;
  logic [1:0]        w_idx;
  logic [23:0]       w_word;
  logic [ADDR_W-1:0] w_addr;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_we;
  logic [ADDR_W-1:0] w_maddr;
  logic [31:0]       w_wdata;
  logic              w_done;
  logic              w_ferr;
  logic              w_last;

  assign w_last = (r_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_maddr <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_word  <= w_word;
      r_addr  <= w_addr;
      r_cnt   <= w_cnt;
      r_we    <= w_we;
      r_maddr <= w_maddr;
      r_wdata <= w_wdata;
      r_done  <= w_done;
      r_ferr  <= w_ferr;
    end
  end

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_word  = r_word;
    w_addr  = r_addr;
    w_cnt   = r_cnt;
    w_we    = 1'b0;
    w_maddr = r_maddr;
    w_wdata = r_wdata;
    w_done  = r_done;
    w_ferr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (en && bus.rx_dv) begin
          w_word  = {16'h0, bus.rx_byte};
          w_idx   = 2'd1;
          w_cnt   = '0;
          w_state = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // en drop beats a byte; a byte beats the timeout
        if (!en) begin
          w_idx   = '0;
          w_cnt   = '0;
          w_state = S_IDLE;
        end else if (bus.rx_dv) begin
          w_cnt = '0;
          if (r_idx == 2'd3) begin
            w_we    = 1'b1;
            w_wdata = {bus.rx_byte, r_word};
            w_maddr = r_addr;
            w_addr  = r_addr + ADDR_W'(1);
            w_idx   = '0;
            w_done  = w_last;
            w_state = w_last ? S_DONE : S_IDLE;
          end else begin
            case (r_idx)
              2'd1:    w_word[15:8]  = bus.rx_byte;
              2'd2:    w_word[23:16] = bus.rx_byte;
              default: w_word[7:0]   = bus.rx_byte;
            endcase
            w_idx = r_idx + 2'd1;
          end
        end else if (r_cnt == TO_LAST) begin
          w_ferr  = 1'b1;
          w_idx   = '0;
          w_cnt   = '0;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state = S_DONE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_maddr;
  assign bus.mem_wdata = r_wdata;
  assign recv_done     = r_done;
  assign frame_err     = r_ferr;
  assign busy          = (r_state == S_COLLECT);

endmodule

// File: tb/tb_uart_word_packer.sv
// Randomized + directed bench for uart_word_packer with a
// queue-based reference model and a decoupled monitor.
module tb_uart_word_packer;

  localparam int WC = 4;
  localparam int AW = 3;
  localparam int TO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en;
  logic recv_done;
  logic frame_err;
  logic busy;

  uart_word_packer_if #(.ADDR_W(AW)) bus ();

  uart_word_packer #(
    .WORD_COUNT  (WC),
    .ADDR_W      (AW),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .recv_done(recv_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t exp_q[$];

  logic [7:0]    partial[$];
  int            gap;
  int            waddr;
  bit            m_done;
  bit            m_we;
  bit            m_ferr;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;

  bit            e_busy;
  bit            e_done;
  bit            e_we;
  bit            e_ferr;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_data;
  bit            chk_on;
  int            ncyc;

  int vectors;
  int miscompares;

  function automatic void chk(
    input string n,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, act, exp, $time);
    end
  endfunction

  // Spec-level model: bytes gather in a queue; 4 make a word,
  // en low or TO idle clocks throw the partial word away.
  task automatic model_step(
    input bit r,
    input bit e,
    input bit dv,
    input logic [7:0] b
  );
    logic [31:0] w;
    m_we   = 1'b0;
    m_ferr = 1'b0;
    if (!r) begin
      partial.delete();
      gap    = 0;
      waddr  = 0;
      m_done = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else if (m_done) begin
      m_we = 1'b0;
    end else if (partial.size() != 0) begin
      if (!e) begin
        partial.delete();
      end else if (dv) begin
        partial.push_back(b);
        gap = 0;
        if (partial.size() == 4) begin
          w = {partial[3], partial[2],
               partial[1], partial[0]};
          exp_q.push_back('{a: AW'(waddr), d: w});
          m_addr = AW'(waddr);
          m_data = w;
          m_we   = 1'b1;
          waddr++;
          if (waddr == WC) m_done = 1'b1;
          partial.delete();
        end
      end else begin
        gap++;
        if (gap == TO) begin
          partial.delete();
          m_ferr = 1'b1;
        end
      end
    end else if (e && dv) begin
      partial.push_back(b);
      gap = 0;
    end
  endtask

  task automatic cyc(
    input bit r,
    input bit e,
    input bit dv,
    input logic [7:0] b
  );
    @(posedge clk);
    #1;
    e_busy = (partial.size() != 0);
    e_done = m_done;
    e_we   = m_we;
    e_ferr = m_ferr;
    e_addr = m_addr;
    e_data = m_data;
    chk_on = (ncyc > 0);
    ncyc++;
    rst         = r;
    en          = e;
    bus.rx_dv   = dv;
    bus.rx_byte = b;
    model_step(r, e, dv, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, 1'b1, 1'b1, b);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("recv_done", 32'(recv_done), 32'(e_done));
      chk("frame_err", 32'(frame_err), 32'(e_ferr));
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      chk("mem_wdata", bus.mem_wdata, e_data);
      if (bus.mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_write: got addr %0h data %0h expected none",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          wr_t x;
          x = exp_q.pop_front();
          chk("sb_addr", 32'(bus.mem_addr), 32'(x.a));
          chk("sb_data", bus.mem_wdata, x.d);
        end
      end
    end
  end

  initial begin
    int g;
    int sel;
    rst         = 1'b0;
    en          = 1'b0;
    bus.rx_dv   = 1'b0;
    bus.rx_byte = 8'h00;
    gap         = 0;
    waddr       = 0;
    m_done      = 1'b0;
    m_we        = 1'b0;
    m_ferr      = 1'b0;
    m_addr      = '0;
    m_data      = '0;
    chk_on      = 1'b0;
    ncyc        = 0;
    vectors     = 0;
    miscompares = 0;

    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);

    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(3);

    do_reset();
    send(8'hAA); send(8'hBB);
    idle(TO + 2);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(2);

    do_reset();
    send(8'h51); send(8'h52); send(8'h53);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h5F);
    idle(2);
    send(8'h61); send(8'h62); send(8'h63); send(8'h64);
    idle(2);

    do_reset();
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    send(8'hA0);
    idle(TO - 1);
    send(8'hA1);
    idle(TO - 1);
    send(8'hA2); send(8'hA3);
    idle(2);

    do_reset();
    for (int i = 0; i < 17; i++) send(8'(8'hC0 + i));
    cyc(1'b1, 1'b0, 1'b1, 8'hEE);
    idle(3);

    do_reset();
    for (int i = 0; i < 10; i++) send(8'(8'h70 + i));
    do_reset();
    send(8'h81); send(8'h82); send(8'h83); send(8'h84);
    idle(2);

    for (int k = 0; k < 500; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)       g = 0;
      else if (sel == 5) g = TO - 1;
      else if (sel == 6) g = TO;
      else if (sel == 7) g = TO - 2;
      else               g = $urandom_range(1, 5);
      for (int i = 0; i < g; i++)
        cyc(1'b1, $urandom_range(0, 40) != 0, 1'b0, 8'h00);
      cyc($urandom_range(0, 60) != 0,
          $urandom_range(0, 20) != 0,
          1'b1, 8'($urandom_range(0, 255)));
      if (m_done && $urandom_range(0, 3) == 0) do_reset();
    end

    idle(4);
    @(negedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_word_packer.md
UART_WORD_PACKER -- requirements
Module: uart_word_packer

Interface
REQ-001 SHALL provide parameter WORD_COUNT, default 1024, meaning the number of 32-bit words per transfer (8*MEM_SIZE bytes / 4 for MEM_SIZE=512).
REQ-002 SHALL provide parameter ADDR_W, default 10, meaning the width of mem_addr; WORD_COUNT <= 2**ADDR_W.
REQ-003 SHALL provide parameter TIMEOUT_CLKS, default 2000, meaning the maximum idle clocks allowed between bytes of one word (about 2 byte frames at CLKS_PER_BIT=100).
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  high = accept bytes; low = abort any partial word.
REQ-007 rx_dv  input  1  one-cycle byte-valid strobe from uart_rx.
REQ-008 rx_byte  input  8  received byte, valid when rx_dv=1.
REQ-009 mem_we  output  1  one-cycle write strobe to word memory.
REQ-010 mem_addr  output  ADDR_W  word address for the current write.
REQ-011 mem_wdata  output  32  assembled word.
REQ-012 recv_done  output  1  level, high once WORD_COUNT words have been written.
REQ-013 frame_err  output  1  one-cycle pulse on inter-byte timeout.
REQ-014 busy  output  1  high while a partial word is held (state COLLECT).

Function
REQ-015 SHALL implement states IDLE, COLLECT and DONE.
REQ-016 IDLE: on rx_dv=1 and en=1, SHALL store rx_byte in bits[7:0], set byte index to 1 and go to COLLECT; with en=0, SHALL ignore rx_dv.
REQ-017 COLLECT: on each rx_dv, SHALL store the byte at bits[8*idx+7:8*idx] (little-endian, first byte = LSB) and increment idx.
REQ-018 On acceptance of the 4th byte, SHALL drive mem_we=1 for exactly one cycle on the following clock, with mem_wdata = full word and mem_addr = current word address.
REQ-019 SHALL increment the word address by 1 after each write; if the written address was WORD_COUNT-1, SHALL enter DONE, otherwise IDLE.
REQ-020 SHALL assert recv_done in the same cycle as the final mem_we and hold it high until reset.
REQ-021 DONE: SHALL ignore rx_dv and en, with no further mem_we.
REQ-022 SHALL run a timeout counter in COLLECT that clears on every accepted byte; on reaching TIMEOUT_CLKS-1 it SHALL discard the partial word, pulse frame_err for one cycle and return to IDLE with the word address unchanged.
REQ-023 If rx_dv coincides with timeout expiry, the byte SHALL be accepted, with no frame_err.
REQ-024 If en falls in COLLECT, SHALL discard the partial word (no frame_err) and go to IDLE with the word address unchanged.
REQ-025 If rx_dv arrives in the cycle mem_we is high, SHALL accept it as byte 0 of the next word.
REQ-026 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-027 On rst=0 at a clock edge, SHALL set state IDLE, byte index 0, word address 0, timeout counter 0, and mem_we, recv_done, frame_err and busy = 0, with mem_addr = 0 and mem_wdata = 0.
REQ-028 Reset mid-word or in DONE SHALL discard all progress; the next transfer SHALL restart at address 0.

Verification
REQ-029 en=1, bytes 0x11,0x22,0x33,0x44 -> one mem_we, mem_addr=0, mem_wdata=0x44332211; busy high from byte 1 to byte 4.
REQ-030 WORD_COUNT=4, 16 bytes back-to-back -> 4 writes at addresses 0..3; recv_done=1 with the 4th mem_we; a 17th byte gives no mem_we.
REQ-031 Bytes 0xAA,0xBB, then idle TIMEOUT_CLKS clocks -> frame_err pulse, busy=0, no mem_we; next 4 bytes 0x01..0x04 -> mem_addr=0, mem_wdata=0x04030201.
REQ-032 en dropped after 3 bytes, then re-raised, 4 new bytes -> exactly one write at address 0 containing only the new bytes, with no frame_err.
REQ-033 rst=0 asserted after 2 of 4 words -> all outputs 0; next word written at address 0.
REQ-034 rx_dv on the cycle of mem_we, plus rx_dv exactly at timeout expiry -> both bytes accepted, with correct next-word data and no frame_err.
